// File: rtl/dqn_sched.sv
// dqn_sched -- top-level sequencer for a DQN training loop.
//
// Walks each training step through four external units (action select,
// environment, target compute, weight update), periodically requests a
// target-network sync, and tracks step / episode / epsilon bookkeeping.
//
// Ports:
//   clk                      single clock, rising edge
//   rst                      synchronous active-low reset
//   start                    begin training (honoured only in IDLE)
//   st1[3:0]                 next environment state, taken with env_done
//   act_done .. upd_done     completion strobes from the four units
//   act_start .. upd_start   one-cycle launch pulses to the four units
//   sync_tgt                 one-cycle pulse: copy online -> target weights
//   step[3:0]                current step within the episode
//   episode[11:0]            completed-episode count
//   epsilon[7:0]             current exploration threshold
//   busy                     high outside IDLE and DONE
//   train_done               high while in DONE
module dqn_sched #(
  parameter int unsigned MAX_STEP    = 15,
  parameter int unsigned MAX_EPISODE = 4095,
  parameter int unsigned SYNC_PERIOD = 8,
  parameter int unsigned GOAL_STATE  = 9,
  parameter int unsigned EPS_INIT    = 255,
  parameter int unsigned EPS_DEC     = 2,
  parameter int unsigned EPS_MIN     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  st1,
  input  logic        act_done,
  input  logic        env_done,
  input  logic        tgt_done,
  input  logic        upd_done,
  output logic        act_start,
  output logic        env_start,
  output logic        tgt_start,
  output logic        upd_start,
  output logic        sync_tgt,
  output logic [3:0]  step,
  output logic [11:0] episode,
  output logic [7:0]  epsilon,
  output logic        busy,
  output logic        train_done
);

  typedef enum logic [2:0] {IDLE, ACT, ENV, TGT, UPD, SYNC, DONE} state_t;

  localparam logic [3:0]  MAX_STEP_C = 4'(MAX_STEP);
  localparam logic [11:0] MAX_EP_C   = 12'(MAX_EPISODE);
  localparam logic [8:0]  SYNC_C     = 9'(SYNC_PERIOD);
  localparam logic [3:0]  GOAL_C     = 4'(GOAL_STATE);
  // Below this value a plain subtract would drop under the floor (or wrap).
  localparam logic [8:0]  EPS_THR    = 9'(EPS_DEC) + 9'(EPS_MIN);

  state_t      state, state_d;
  logic [7:0]  sync_cnt, sync_cnt_d;
  logic        term, term_d;
  logic [3:0]  step_d;
  logic [11:0] episode_d;
  logic [7:0]  epsilon_d;
  logic        act_start_d, env_start_d, tgt_start_d, upd_start_d;
  logic        sync_tgt_d, busy_d, train_done_d;

  // Shared decision terms.
  logic sync_hit;   // this upd_done completes a sync period
  logic ep_end;     // the step just finished closes the episode
  logic last_ep;    // closing this episode finishes training
  logic check;      // episode-end evaluation happens on this edge

  assign sync_hit = ({1'b0, sync_cnt} + 9'd1) == SYNC_C;
  assign ep_end   = term || (step == MAX_STEP_C);
  assign last_ep  = (episode + 12'd1) == MAX_EP_C;
  assign check    = ((state == UPD) && upd_done && !sync_hit) || (state == SYNC);

  // State and every output are registered together.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sync_cnt   <= '0;
      term       <= 1'b0;
      step       <= '0;
      episode    <= '0;
      epsilon    <= 8'(EPS_INIT);
      act_start  <= 1'b0;
      env_start  <= 1'b0;
      tgt_start  <= 1'b0;
      upd_start  <= 1'b0;
      sync_tgt   <= 1'b0;
      busy       <= 1'b0;
      train_done <= 1'b0;
    end else begin
      state      <= state_d;
      sync_cnt   <= sync_cnt_d;
      term       <= term_d;
      step       <= step_d;
      episode    <= episode_d;
      epsilon    <= epsilon_d;
      act_start  <= act_start_d;
      env_start  <= env_start_d;
      tgt_start  <= tgt_start_d;
      upd_start  <= upd_start_d;
      sync_tgt   <= sync_tgt_d;
      busy       <= busy_d;
      train_done <= train_done_d;
    end
  end

  // Next-state logic. Done strobes for other states are simply not looked at.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start)    state_d = ACT;
      ACT:  if (act_done) state_d = ENV;
      ENV:  if (env_done) state_d = TGT;
      TGT:  if (tgt_done) state_d = UPD;
      UPD:  if (upd_done) begin
              if (sync_hit)              state_d = SYNC;
              else if (ep_end && last_ep) state_d = DONE;
              else                       state_d = ACT;
            end
      SYNC: state_d = (ep_end && last_ep) ? DONE : ACT;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    // Launch pulses fire only on entry, so each lasts exactly one cycle.
    act_start_d  = (state_d == ACT) && (state != ACT);
    env_start_d  = (state_d == ENV) && (state != ENV);
    tgt_start_d  = (state_d == TGT) && (state != TGT);
    upd_start_d  = (state_d == UPD) && (state != UPD);
    sync_tgt_d   = (state_d == SYNC);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    train_done_d = (state_d == DONE);

    step_d     = step;
    episode_d  = episode;
    epsilon_d  = epsilon;
    term_d     = term;
    sync_cnt_d = sync_cnt;

    if ((state == IDLE) && start) begin
      step_d = 4'd1;
      term_d = 1'b0;
    end

    if ((state == ENV) && env_done)
      term_d = (st1 == GOAL_C);

    // The counter deliberately survives episode boundaries.
    if ((state == UPD) && upd_done)
      sync_cnt_d = sync_hit ? 8'd0 : sync_cnt + 8'd1;

    if (check) begin
      if (ep_end) begin
        episode_d = episode + 12'd1;
        step_d    = 4'd1;
        term_d    = 1'b0;
        epsilon_d = ({1'b0, epsilon} >= EPS_THR) ? epsilon - 8'(EPS_DEC)
                                                 : 8'(EPS_MIN);
      end else begin
        step_d = step + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dqn_sched.sv
// tb_dqn_sched -- randomized directed bench for dqn_sched.
// A transaction-level model (step, episode, epsilon, sync count) predicts
// what each training step must show; units answer after random delays and
// stray done strobes are injected while a unit is busy.
module tb_dqn_sched;

  localparam int MAX_STEP    = 3;
  localparam int MAX_EPISODE = 4;
  localparam int SYNC_PERIOD = 3;
  localparam int GOAL        = 9;
  localparam int EPS_INIT    = 20;
  localparam int EPS_DEC     = 8;
  localparam int EPS_MIN     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  st1;
  logic [3:0]  dn;          // {upd, tgt, env, act} done strobes
  logic        act_start, env_start, tgt_start, upd_start, sync_tgt;
  logic [3:0]  step;
  logic [11:0] episode;
  logic [7:0]  epsilon;
  logic        busy, train_done;
  logic [3:0]  starts;

  assign starts = {upd_start, tgt_start, env_start, act_start};

  dqn_sched #(
    .MAX_STEP(MAX_STEP), .MAX_EPISODE(MAX_EPISODE), .SYNC_PERIOD(SYNC_PERIOD),
    .GOAL_STATE(GOAL), .EPS_INIT(EPS_INIT), .EPS_DEC(EPS_DEC), .EPS_MIN(EPS_MIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .st1(st1),
    .act_done(dn[0]), .env_done(dn[1]), .tgt_done(dn[2]), .upd_done(dn[3]),
    .act_start(act_start), .env_start(env_start), .tgt_start(tgt_start),
    .upd_start(upd_start), .sync_tgt(sync_tgt), .step(step), .episode(episode),
    .epsilon(epsilon), .busy(busy), .train_done(train_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  int m_step, m_ep, m_eps, m_sync;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_step = 1; m_ep = 0; m_eps = EPS_INIT; m_sync = 0; m_done = 0;
  endtask

  // Wait (bounded) until launch pulse idx is visible.
  task automatic wait_start(input int idx, output bit seen);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (starts[idx]) begin seen = 1; break; end
      @(negedge clk);
    end
  endtask

  // Service one unit: see its pulse, wait a random delay (with strays),
  // then return done. Ends at the negedge after the accepting edge.
  task automatic run_unit(input int idx, input logic [3:0] s1);
    bit seen;
    int d, j;
    wait_start(idx, seen);
    check($sformatf("start%0d_seen", idx), 32'(seen), 1);
    if (!seen) return;
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      j = $urandom_range(0, 3);
      if (j != idx) dn[j] = 1'b1;
      st1 = 4'($urandom_range(0, 15));
      @(negedge clk);
      dn = '0;
      check($sformatf("no_pulse_wait%0d", idx), 32'(starts), 0);
    end
    dn[idx] = 1'b1;
    st1 = s1;
    @(negedge clk);
    dn = '0;
    st1 = 4'($urandom_range(0, 15));
  endtask

  // One full training step against the model.
  task automatic do_step(input logic [3:0] s1);
    bit seen, hit, term;
    int e;
    wait_start(0, seen);
    check("act_start_seen", 32'(seen), 1);
    check("step_at_act", 32'(step), 32'(m_step));
    check("episode_at_act", 32'(episode), 32'(m_ep));
    check("epsilon_at_act", 32'(epsilon), 32'(m_eps));
    check("busy_at_act", 32'(busy), 1);
    run_unit(0, 4'($urandom_range(0, 15)));
    run_unit(1, s1);
    run_unit(2, 4'($urandom_range(0, 15)));
    run_unit(3, 4'($urandom_range(0, 15)));
    m_sync++;
    hit = (m_sync == SYNC_PERIOD);
    if (hit) m_sync = 0;
    check("sync_tgt_after_upd", 32'(sync_tgt), 32'(hit));
    if (hit) begin
      check("no_act_in_sync", 32'(act_start), 0);
      @(negedge clk);
      check("sync_one_cycle", 32'(sync_tgt), 0);
    end
    term = (s1 == GOAL);
    if (term || m_step == MAX_STEP) begin
      m_ep++;
      m_step = 1;
      e = m_eps - EPS_DEC;
      m_eps = (e < EPS_MIN) ? EPS_MIN : e;
      if (m_ep == MAX_EPISODE) m_done = 1;
    end else begin
      m_step++;
    end
    if (m_done) begin
      check("train_done_set", 32'(train_done), 1);
      check("busy_in_done", 32'(busy), 0);
      check("episode_final", 32'(episode), 32'(m_ep));
      check("epsilon_final", 32'(epsilon), 32'(m_eps));
    end else begin
      check("act_follows", 32'(act_start), 1);
    end
  endtask

  task automatic run_training(input bit force_goal);
    logic [3:0] s1;
    int n;
    model_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!m_done && n < 40) begin
      if (force_goal && n == 0) s1 = 4'(GOAL);
      else if ($urandom_range(0, 3) == 0) s1 = 4'(GOAL);
      else s1 = 4'($urandom_range(0, 15));
      do_step(s1);
      n++;
    end
    check("training_completed", 32'(m_done), 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_step"}, 32'(step), 0);
    check({tag, "_episode"}, 32'(episode), 0);
    check({tag, "_epsilon"}, 32'(epsilon), 32'(EPS_INIT));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pulses"}, 32'({starts, sync_tgt, train_done}), 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; start = 1'b0; st1 = '0; dn = '0;

    // Reset held for three edges.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_idle("reset");

    // Done strobes in IDLE are ignored.
    dn = 4'b1111;
    @(negedge clk);
    dn = '0;
    @(negedge clk);
    check_idle("idle_strays");

    // First training run; the first step hits the goal state.
    run_training(1'b1);

    // DONE holds and ignores start.
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("done_hold", 32'(train_done), 1);
    check("done_episode", 32'(episode), 32'(MAX_EPISODE));
    check("done_no_pulse", 32'(starts), 0);

    // Reset out of DONE, restart, then reset while in TGT.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("reset_from_done");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_unit(0, 4'd0);
    run_unit(1, 4'(GOAL));
    wait_start(2, seen);
    check("tgt_reached", 32'(seen), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("reset_in_tgt");
    dn[2] = 1'b1;
    @(negedge clk);
    dn = '0;
    @(negedge clk);
    check_idle("late_tgt_done");

    // Second run from a clean reset: sync count and terminal flag start fresh.
    run_training(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
